pixel_scan_scheduler: RTL and testbench
=======================================

Name: pixel_scan_scheduler

Overview:
Frame-level controller for the pixel-to-complex converter.
- On start, latches a view configuration (screen size, zoom, centre) into shadow registers and drives it to the converter for the whole frame.
- Walks x/y in raster order and waits out the converter latency.
- Offers each converted point as a job to the downstream iteration engines over a valid/ready handshake.
- Sits between the host/config registers and the Mandelbrot iteration engine pool.

Parameters:
- WORD_LENGTH, 64, fixed-point word width of centre and complex coordinates.
- FRAC, 60, fractional bits (converter format).
- COORD_W, 11, width of x/y pixel coordinates; maximum screen dimension is 2^COORD_W.
- CONV_LATENCY, 1, converter clock latency from x/y change to valid real/imag; must be 1 or more.
- DEFAULT_WIDTH, 640, reset value of the shadow width.
- DEFAULT_HEIGHT, 480, reset value of the shadow height.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a frame; sampled only in IDLE.
- abort  in  1  terminate the current frame.
- cfg_width  in  32  requested screen width.
- cfg_height  in  32  requested screen height.
- cfg_zoom  in  32  requested zoom.
- cfg_real_center  in  WORD_LENGTH  requested real centre (signed).
- cfg_imag_center  in  WORD_LENGTH  requested imaginary centre (signed).
- cv_width, cv_height, cv_zoom  out  32  shadowed configuration to the converter.
- cv_real_center, cv_imag_center  out  WORD_LENGTH  shadowed centre to the converter.
- pix_x, pix_y  out  COORD_W  coordinate to the converter.
- conv_real, conv_imag  in  WORD_LENGTH  converter outputs.
- job_valid  out  1  job offered.
- job_ready  in  1  engine accepts the job.
- job_real, job_imag  out  WORD_LENGTH  point c; combinational pass-through of conv_real/conv_imag.
- job_x, job_y  out  COORD_W  equal to pix_x/pix_y.
- job_last  out  1  job is the final pixel of the frame.
- busy  out  1  state is not IDLE.
- frame_done  out  1  one-cycle pulse at frame end.
- cfg_error  out  1  sticky flag: last start had illegal configuration.

Behaviour:
Reset values:
- State IDLE; pix_x = pix_y = 0.
- cv_width = DEFAULT_WIDTH, cv_height = DEFAULT_HEIGHT, cv_zoom = 1, centres 0. This keeps the converter divisors nonzero at all times.
- job_valid, busy, frame_done, cfg_error all 0.

States: IDLE, WAIT, OFFER, DONE.

IDLE:
- start=1 with cfg_width, cfg_height, cfg_zoom all in 1..2^COORD_W range (zoom at least 1):
  - capture all cfg_* into shadows;
  - pix_x = pix_y = 0; wait counter = CONV_LATENCY; cfg_error cleared; go to WAIT.
- start=1 with an illegal config:
  - shadows unchanged; cfg_error set; go to DONE; no jobs issued.

WAIT:
- Counter decrements each cycle.
- When counter reaches 1, go to OFFER, so WAIT lasts exactly CONV_LATENCY cycles.

OFFER:
- job_valid = 1. pix_x/pix_y and the shadows are held, so the converter output stays stable.
- job_valid and the job fields stay constant until job_ready is seen.
- job_last = (pix_x == cv_width-1) and (pix_y == cv_height-1).
- On job_valid and job_ready:
  - if job_last, go to DONE;
  - else pix_x+1 (on pix_x == cv_width-1: pix_x wraps to 0 and pix_y+1), reload the counter, go to WAIT.
- Throughput is 1 pixel per CONV_LATENCY+1 cycles when job_ready is held high.

DONE:
- frame_done = 1 for exactly one cycle, then go to IDLE.
- start during DONE is ignored.

Abort:
- abort=1 in WAIT or OFFER sends the block to IDLE on the next edge with no frame_done.
- abort beats a simultaneous handshake; that job counts as not accepted.
- abort in IDLE or DONE has no effect.

Other rules:
- cfg_* changes while busy are ignored until the next start.
- start while busy is ignored.
- Coordinate counters are unsigned. Comparisons use the shadows zero-extended to 32 bits.
- rst asserted mid-frame returns everything to reset values immediately, with no frame_done.

Decomposition:
- Package mandel_pkg holds:
  - WORD_LENGTH, FRAC, COORD_W;
  - the scan_state_t enum;
  - the view_cfg_t struct (width, height, zoom, real_center, imag_center), used for both the cfg_* and cv_* bundles.
- One sub-module, raster_counter: holds x/y, with inputs clear and advance, and outputs x, y and last, given width and height.

Test Plan:
- 4x3 frame, zoom 1, centres 0, job_ready held 1, CONV_LATENCY=1, behavioural converter:
  - 12 jobs in raster order, job_valid every 2nd cycle;
  - job_real for x=1 equals -0.75*2^60;
  - job_last only on (3,2); frame_done pulse one cycle after that handshake.
- Same frame with job_ready low for 5 cycles on pixel (2,1): job_valid, job_x=2, job_y=1 and job_real stay constant through the stall; no pixel dropped or duplicated.
- cfg_width changed to 8 and cfg_zoom to 4 mid-frame: cv_* are unchanged and exactly 12 jobs are issued. The next start uses the new values.
- abort asserted in the same cycle as a handshake on pixel (1,0): IDLE next cycle, job_valid=0, no frame_done, busy=0.
- start with cfg_zoom=0 (and separately cfg_width=4096): no jobs, cfg_error=1, frame_done pulses, cv_* keep their previous values.
- rst pulse mid-frame at pixel (3,1): outputs return to reset values (cv_width=640); a new start then runs a full frame from (0,0).

Source files
------------

// File: rtl/mandel_pkg.sv
// Shared types and constants for the Mandelbrot frame pipeline: fixed-point
// formats, scan-state encoding and the view configuration bundle.
package mandel_pkg;

   localparam int WORD_LENGTH = 64;
   localparam int FRAC        = 60;
   localparam int COORD_W     = 11;
   localparam int CFG_W       = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_OFFER = 2'd2,
      ST_DONE  = 2'd3
   } scan_state_t;

   typedef struct packed {
      logic [CFG_W-1:0]              width;
      logic [CFG_W-1:0]              height;
      logic [CFG_W-1:0]              zoom;
      logic signed [WORD_LENGTH-1:0] real_center;
      logic signed [WORD_LENGTH-1:0] imag_center;
   } view_cfg_t;

   // Width, height and zoom must each lie in 1..2^COORD_W.
   function automatic logic cfg_is_legal(input view_cfg_t c);
      logic [CFG_W-1:0] max_dim;
      max_dim = CFG_W'(1) << COORD_W;
      return (c.width  != '0) && (c.width  <= max_dim) &&
             (c.height != '0) && (c.height <= max_dim) &&
             (c.zoom   != '0) && (c.zoom   <= max_dim);
   endfunction

endpackage

// File: rtl/raster_counter.sv
// Raster-order x/y pixel counter: clear restarts at (0,0), advance steps one
// pixel, wrapping x at width-1 into the next row.
module raster_counter
   import mandel_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               clear,
   input  logic               advance,
   input  logic [CFG_W-1:0]   width,
   input  logic [CFG_W-1:0]   height,
   output logic [COORD_W-1:0] x,
   output logic [COORD_W-1:0] y,
   output logic               last
);

   logic [COORD_W-1:0] x_q, x_d;
   logic [COORD_W-1:0] y_q, y_d;
   logic               x_at_end;
   logic               y_at_end;

   always_comb begin
      x_at_end = (CFG_W'(x_q) == (width  - CFG_W'(1)));
      y_at_end = (CFG_W'(y_q) == (height - CFG_W'(1)));
      x_d      = x_q;
      y_d      = y_q;
      if (clear) begin
         x_d = '0;
         y_d = '0;
      end else if (advance) begin
         if (x_at_end) begin
            x_d = '0;
            y_d = y_q + COORD_W'(1);
         end else begin
            x_d = x_q + COORD_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x_q <= '0;
         y_q <= '0;
      end else begin
         x_q <= x_d;
         y_q <= y_d;
      end
   end

   assign x    = x_q;
   assign y    = y_q;
   assign last = x_at_end && y_at_end;

endmodule

// File: rtl/pixel_scan_scheduler.sv
// Frame controller: shadows the view configuration, walks pixels in raster
// order, waits out converter latency and offers each point as a job.
module pixel_scan_scheduler
   import mandel_pkg::*;
#(
   parameter int CONV_LATENCY   = 1,
   parameter int DEFAULT_WIDTH  = 640,
   parameter int DEFAULT_HEIGHT = 480
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic                          abort,
   input  logic [31:0]                   cfg_width,
   input  logic [31:0]                   cfg_height,
   input  logic [31:0]                   cfg_zoom,
   input  logic signed [WORD_LENGTH-1:0] cfg_real_center,
   input  logic signed [WORD_LENGTH-1:0] cfg_imag_center,
   output logic [31:0]                   cv_width,
   output logic [31:0]                   cv_height,
   output logic [31:0]                   cv_zoom,
   output logic signed [WORD_LENGTH-1:0] cv_real_center,
   output logic signed [WORD_LENGTH-1:0] cv_imag_center,
   output logic [COORD_W-1:0]            pix_x,
   output logic [COORD_W-1:0]            pix_y,
   input  logic signed [WORD_LENGTH-1:0] conv_real,
   input  logic signed [WORD_LENGTH-1:0] conv_imag,
   output logic                          job_valid,
   input  logic                          job_ready,
   output logic signed [WORD_LENGTH-1:0] job_real,
   output logic signed [WORD_LENGTH-1:0] job_imag,
   output logic [COORD_W-1:0]            job_x,
   output logic [COORD_W-1:0]            job_y,
   output logic                          job_last,
   output logic                          busy,
   output logic                          frame_done,
   output logic                          cfg_error
);

   localparam int               CNT_W      = (CONV_LATENCY > 1) ? $clog2(CONV_LATENCY + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(CONV_LATENCY);

   scan_state_t      state_q, state_d;
   view_cfg_t        shadow_q, shadow_d;
   view_cfg_t        cfg_in;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             cfg_error_q, cfg_error_d;
   logic             cfg_ok;
   logic             raster_clear;
   logic             raster_advance;
   logic             raster_last;

   always_comb begin
      cfg_in.width       = cfg_width;
      cfg_in.height      = cfg_height;
      cfg_in.zoom        = cfg_zoom;
      cfg_in.real_center = cfg_real_center;
      cfg_in.imag_center = cfg_imag_center;
      cfg_ok             = cfg_is_legal(cfg_in);
   end

   raster_counter u_raster (
      .clk     (clk),
      .rst     (rst),
      .clear   (raster_clear),
      .advance (raster_advance),
      .width   (shadow_q.width),
      .height  (shadow_q.height),
      .x       (pix_x),
      .y       (pix_y),
      .last    (raster_last)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Abort has priority over a handshake in the same cycle.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (start) state_d = cfg_ok ? ST_WAIT : ST_DONE;
         ST_WAIT: begin
            if (abort)                       state_d = ST_IDLE;
            else if (cnt_q == CNT_W'(1))     state_d = ST_OFFER;
         end
         ST_OFFER: begin
            if (abort)                       state_d = ST_IDLE;
            else if (job_ready)              state_d = raster_last ? ST_DONE : ST_WAIT;
         end
         ST_DONE:                            state_d = ST_IDLE;
         default:                            state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      job_valid  = (state_q == ST_OFFER);
      busy       = (state_q != ST_IDLE);
      frame_done = (state_q == ST_DONE);
   end

   always_comb begin
      shadow_d       = shadow_q;
      cnt_d          = cnt_q;
      cfg_error_d    = cfg_error_q;
      raster_clear   = 1'b0;
      raster_advance = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               cfg_error_d = !cfg_ok;
               if (cfg_ok) begin
                  shadow_d     = cfg_in;
                  cnt_d        = CNT_RELOAD;
                  raster_clear = 1'b1;
               end
            end
         end
         ST_WAIT:  cnt_d = cnt_q - CNT_W'(1);
         ST_OFFER: begin
            if (!abort && job_ready && !raster_last) begin
               raster_advance = 1'b1;
               cnt_d          = CNT_RELOAD;
            end
         end
         default: ;
      endcase
   end

   // Shadow reset values keep the converter's divisors nonzero out of reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow_q.width       <= 32'(DEFAULT_WIDTH);
         shadow_q.height      <= 32'(DEFAULT_HEIGHT);
         shadow_q.zoom        <= 32'd1;
         shadow_q.real_center <= '0;
         shadow_q.imag_center <= '0;
         cnt_q                <= '0;
         cfg_error_q          <= 1'b0;
      end else begin
         shadow_q             <= shadow_d;
         cnt_q                <= cnt_d;
         cfg_error_q          <= cfg_error_d;
      end
   end

   assign cv_width       = shadow_q.width;
   assign cv_height      = shadow_q.height;
   assign cv_zoom        = shadow_q.zoom;
   assign cv_real_center = shadow_q.real_center;
   assign cv_imag_center = shadow_q.imag_center;
   assign cfg_error      = cfg_error_q;

   assign job_real = conv_real;
   assign job_imag = conv_imag;
   assign job_x    = pix_x;
   assign job_y    = pix_y;
   assign job_last = raster_last;

endmodule

// File: tb/tb_pixel_scan_scheduler.sv
// Bench for pixel_scan_scheduler: behavioural converter plus a raster-order
// job model; scenario tasks compare accepted jobs against that model.
module tb_pixel_scan_scheduler;
   import mandel_pkg::*;

   typedef struct {
      int     x;
      int     y;
      longint re;
      longint im;
      bit     last;
      bit     vld;
      int     cyc;
   } job_rec_t;

   logic                          clk = 1'b0;
   logic                          rst, start, abort, job_ready;
   logic [31:0]                   cfg_width, cfg_height, cfg_zoom;
   logic signed [WORD_LENGTH-1:0] cfg_real_center, cfg_imag_center;
   logic [31:0]                   cv_width, cv_height, cv_zoom;
   logic signed [WORD_LENGTH-1:0] cv_real_center, cv_imag_center;
   logic [COORD_W-1:0]            pix_x, pix_y, job_x, job_y;
   logic signed [WORD_LENGTH-1:0] conv_real = '0, conv_imag = '0;
   logic signed [WORD_LENGTH-1:0] job_real, job_imag;
   logic                          job_valid, job_last, busy, frame_done, cfg_error;

   int       n_checks = 0;
   int       n_pass   = 0;
   int       cyc      = 0;
   job_rec_t exp_q[$];
   job_rec_t acc_q[$];
   job_rec_t stall_q[$];
   bit       done_seen, timed_out, done_after, busy_after;
   int       done_cyc;

   pixel_scan_scheduler dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_zoom(cfg_zoom),
      .cfg_real_center(cfg_real_center), .cfg_imag_center(cfg_imag_center),
      .cv_width(cv_width), .cv_height(cv_height), .cv_zoom(cv_zoom),
      .cv_real_center(cv_real_center), .cv_imag_center(cv_imag_center),
      .pix_x(pix_x), .pix_y(pix_y), .conv_real(conv_real), .conv_imag(conv_imag),
      .job_valid(job_valid), .job_ready(job_ready), .job_real(job_real), .job_imag(job_imag),
      .job_x(job_x), .job_y(job_y), .job_last(job_last),
      .busy(busy), .frame_done(frame_done), .cfg_error(cfg_error)
   );

   always #5 clk = ~clk;

   // Point = centre + (coord - dim/2) * 3.0 / (width * zoom), Q(FRAC).
   function automatic longint conv_model(input longint w, input longint z, input longint center,
                                         input longint coord, input longint dim);
      longint div, stp;
      div = 2 * w * z;
      if (div == 0) return center;
      stp = (longint'(3) <<< FRAC) / div;
      return center + (2 * coord - dim) * stp;
   endfunction

   always @(posedge clk) begin
      conv_real <= conv_model(longint'(cv_width), longint'(cv_zoom), cv_real_center,
                              longint'(pix_x), longint'(cv_width));
      conv_imag <= conv_model(longint'(cv_width), longint'(cv_zoom), cv_imag_center,
                              longint'(pix_y), longint'(cv_height));
   end

   function automatic job_rec_t rec_now();
      job_rec_t r;
      r.x = int'(job_x);  r.y = int'(job_y);
      r.re = job_real;    r.im = job_imag;
      r.last = job_last;  r.vld = job_valid;  r.cyc = cyc;
      return r;
   endfunction

   function automatic void build_expected(input int w, input int h, input int z,
                                          input longint rc, input longint ic);
      exp_q.delete();
      for (int yy = 0; yy < h; yy++) begin
         for (int xx = 0; xx < w; xx++) begin
            job_rec_t e;
            e.x = xx;  e.y = yy;
            e.re = conv_model(w, z, rc, xx, w);
            e.im = conv_model(w, z, ic, yy, h);
            e.last = (xx == w - 1) && (yy == h - 1);
            e.vld = 1'b1;  e.cyc = 0;
            exp_q.push_back(e);
         end
      end
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic start_frame(input int w, input int h, input int z, input longint rc, input longint ic);
      cfg_width = 32'(w);  cfg_height = 32'(h);  cfg_zoom = 32'(z);
      cfg_real_center = rc;  cfg_imag_center = ic;
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   // Runs one frame, recording accepted jobs and stall samples.
   task automatic drive_frame(input int w, input int h, input int z, input longint rc, input longint ic,
                              input int stall_idx, input int stall_len, input bit rand_ready,
                              input int chg_idx, input int max_cycles);
      int n_acc, stall_cnt, budget;
      acc_q.delete();  stall_q.delete();
      done_seen = 0;  timed_out = 0;  done_after = 0;  busy_after = 0;
      n_acc = 0;  stall_cnt = 0;  budget = 0;
      start_frame(w, h, z, rc, ic);
      while (!done_seen && !timed_out) begin
         if (frame_done) begin
            done_seen = 1;
            done_cyc  = cyc;
         end else if (budget >= max_cycles) begin
            timed_out = 1;
         end else begin
            if (n_acc == chg_idx) begin
               cfg_width = 32'd8;
               cfg_zoom  = 32'd4;
            end
            if (n_acc == stall_idx && (job_valid || stall_cnt > 0) && stall_cnt < stall_len) begin
               job_ready = 1'b0;
               stall_cnt++;
               stall_q.push_back(rec_now());
            end else if (rand_ready) begin
               job_ready = 1'($urandom_range(0, 1));
            end else begin
               job_ready = 1'b1;
            end
            if (job_valid && job_ready) begin
               acc_q.push_back(rec_now());
               n_acc++;
            end
            step();
            budget++;
         end
      end
      job_ready = 1'b0;
      if (done_seen) begin
         step();
         done_after = frame_done;
         busy_after = busy;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      n_checks++; if (cv_width !== 32'd640) $display("FAIL reset_cv_width got %0d want 640", cv_width); else n_pass++;
      step();
      rst = 1'b0;
      step();
      n_checks++; if (cv_height !== 32'd480) $display("FAIL reset_cv_height got %0d want 480", cv_height); else n_pass++;
      n_checks++; if (cv_zoom !== 32'd1) $display("FAIL reset_cv_zoom got %0d want 1", cv_zoom); else n_pass++;
      n_checks++; if (cv_real_center !== 0 || cv_imag_center !== 0)
         $display("FAIL reset_centres got %0d/%0d want 0/0", cv_real_center, cv_imag_center); else n_pass++;
      n_checks++; if (pix_x !== 0 || pix_y !== 0) $display("FAIL reset_pix got (%0d,%0d) want (0,0)", pix_x, pix_y); else n_pass++;
      n_checks++; if ({job_valid, busy, frame_done, cfg_error} !== 4'b0000)
         $display("FAIL reset_flags got %b want 0000", {job_valid, busy, frame_done, cfg_error}); else n_pass++;
   endtask

   task automatic test_basic_frame();
      int bad_gap;
      drive_frame(4, 3, 1, 0, 0, -1, 0, 0, -1, 200);
      build_expected(4, 3, 1, 0, 0);
      n_checks++; if (timed_out) $display("FAIL basic_timeout got timeout want frame_done"); else n_pass++;
      n_checks++; if (acc_q.size() != 12) $display("FAIL basic_count got %0d want 12", acc_q.size()); else n_pass++;
      for (int i = 0; i < acc_q.size() && i < exp_q.size(); i++) begin
         n_checks++;
         if (acc_q[i].x !== exp_q[i].x || acc_q[i].y !== exp_q[i].y || acc_q[i].re !== exp_q[i].re ||
             acc_q[i].im !== exp_q[i].im || acc_q[i].last !== exp_q[i].last)
            $display("FAIL basic_job%0d got (%0d,%0d) re=%0d im=%0d last=%0b want (%0d,%0d) re=%0d im=%0d last=%0b",
                     i, acc_q[i].x, acc_q[i].y, acc_q[i].re, acc_q[i].im, acc_q[i].last,
                     exp_q[i].x, exp_q[i].y, exp_q[i].re, exp_q[i].im, exp_q[i].last);
         else n_pass++;
      end
      bad_gap = 0;
      for (int i = 1; i < acc_q.size(); i++) if (acc_q[i].cyc - acc_q[i-1].cyc != 2) bad_gap++;
      n_checks++; if (bad_gap != 0) $display("FAIL basic_cadence got %0d irregular gaps want 0", bad_gap); else n_pass++;
      if (acc_q.size() == 12) begin
         n_checks++; if (acc_q[1].re !== -64'sd864691128455135232)
            $display("FAIL basic_real_x1 got %0d want -864691128455135232", acc_q[1].re); else n_pass++;
         n_checks++; if (done_cyc !== acc_q[11].cyc + 1)
            $display("FAIL basic_done_timing got cycle %0d want %0d", done_cyc, acc_q[11].cyc + 1); else n_pass++;
      end
      n_checks++; if (done_after !== 1'b0 || busy_after !== 1'b0)
         $display("FAIL basic_done_pulse got done=%0b busy=%0b want 0/0", done_after, busy_after); else n_pass++;
   endtask

   task automatic test_stall();
      longint rc, ic;
      rc = 64'sh0100_0000_0000_0000;
      ic = -64'sh0080_0000_0000_0000;
      drive_frame(4, 3, 1, rc, ic, 6, 5, 0, -1, 200);
      build_expected(4, 3, 1, rc, ic);
      n_checks++; if (acc_q.size() != 12) $display("FAIL stall_count got %0d want 12", acc_q.size()); else n_pass++;
      for (int i = 0; i < acc_q.size() && i < exp_q.size(); i++) begin
         n_checks++;
         if (acc_q[i].x !== exp_q[i].x || acc_q[i].y !== exp_q[i].y || acc_q[i].re !== exp_q[i].re)
            $display("FAIL stall_job%0d got (%0d,%0d) re=%0d want (%0d,%0d) re=%0d",
                     i, acc_q[i].x, acc_q[i].y, acc_q[i].re, exp_q[i].x, exp_q[i].y, exp_q[i].re);
         else n_pass++;
      end
      n_checks++; if (stall_q.size() != 5) $display("FAIL stall_samples got %0d want 5", stall_q.size()); else n_pass++;
      for (int i = 0; i < stall_q.size(); i++) begin
         n_checks++;
         if (stall_q[i].vld !== 1'b1 || stall_q[i].x !== 2 || stall_q[i].y !== 1 ||
             stall_q[i].re !== conv_model(4, 1, rc, 2, 4))
            $display("FAIL stall_hold%0d got vld=%0b (%0d,%0d) re=%0d want vld=1 (2,1) re=%0d",
                     i, stall_q[i].vld, stall_q[i].x, stall_q[i].y, stall_q[i].re, conv_model(4, 1, rc, 2, 4));
         else n_pass++;
      end
   endtask

   task automatic test_cfg_change();
      int bad;
      drive_frame(4, 3, 1, 0, 0, -1, 0, 0, 5, 200);
      build_expected(4, 3, 1, 0, 0);
      n_checks++; if (acc_q.size() != 12) $display("FAIL cfgchg_count got %0d want 12", acc_q.size()); else n_pass++;
      bad = 0;
      for (int i = 0; i < acc_q.size() && i < exp_q.size(); i++)
         if (acc_q[i].x !== exp_q[i].x || acc_q[i].y !== exp_q[i].y || acc_q[i].re !== exp_q[i].re) bad++;
      n_checks++; if (bad != 0) $display("FAIL cfgchg_jobs got %0d wrong jobs want 0", bad); else n_pass++;
      n_checks++; if (cv_width !== 32'd4 || cv_zoom !== 32'd1)
         $display("FAIL cfgchg_shadow got w=%0d z=%0d want w=4 z=1", cv_width, cv_zoom); else n_pass++;
      drive_frame(8, 3, 4, 0, 0, -1, 0, 0, -1, 400);
      build_expected(8, 3, 4, 0, 0);
      n_checks++; if (cv_width !== 32'd8 || cv_zoom !== 32'd4)
         $display("FAIL cfgchg_next_shadow got w=%0d z=%0d want w=8 z=4", cv_width, cv_zoom); else n_pass++;
      bad = (acc_q.size() != 24) ? 1 : 0;
      for (int i = 0; i < acc_q.size() && i < exp_q.size(); i++)
         if (acc_q[i].x !== exp_q[i].x || acc_q[i].y !== exp_q[i].y || acc_q[i].re !== exp_q[i].re) bad++;
      n_checks++; if (bad != 0) $display("FAIL cfgchg_next_jobs got %0d errors (n=%0d) want 0 (n=24)", bad, acc_q.size()); else n_pass++;
   endtask

   task automatic test_abort();
      int  budget;
      bit  saw_done;
      start_frame(4, 3, 1, 0, 0);
      job_ready = 1'b1;
      budget = 0;
      while (!(job_valid && job_x == 1 && job_y == 0) && budget < 20) begin
         step();
         budget++;
      end
      n_checks++; if (budget >= 20) $display("FAIL abort_reach got timeout want pixel (1,0)"); else n_pass++;
      abort = 1'b1;
      step();
      abort = 1'b0;
      job_ready = 1'b0;
      n_checks++; if ({job_valid, busy, frame_done} !== 3'b000)
         $display("FAIL abort_idle got vld/busy/done=%b want 000", {job_valid, busy, frame_done}); else n_pass++;
      saw_done = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (frame_done || busy) saw_done = 1;
      end
      n_checks++; if (saw_done) $display("FAIL abort_quiet got activity after abort want none"); else n_pass++;
   endtask

   task automatic test_illegal_cfg();
      drive_frame(4, 3, 0, 0, 0, -1, 0, 0, -1, 50);
      n_checks++; if (!done_seen || acc_q.size() != 0)
         $display("FAIL illegal_zoom got done=%0b jobs=%0d want done=1 jobs=0", done_seen, acc_q.size()); else n_pass++;
      n_checks++; if (cfg_error !== 1'b1 || cv_width !== 32'd4 || cv_zoom !== 32'd1)
         $display("FAIL illegal_zoom_state got err=%0b w=%0d z=%0d want err=1 w=4 z=1", cfg_error, cv_width, cv_zoom); else n_pass++;
      drive_frame(4096, 3, 1, 0, 0, -1, 0, 0, -1, 50);
      n_checks++; if (!done_seen || acc_q.size() != 0)
         $display("FAIL illegal_width got done=%0b jobs=%0d want done=1 jobs=0", done_seen, acc_q.size()); else n_pass++;
      n_checks++; if (cfg_error !== 1'b1 || cv_width !== 32'd4)
         $display("FAIL illegal_width_state got err=%0b w=%0d want err=1 w=4", cfg_error, cv_width); else n_pass++;
      drive_frame(2, 2, 1, 0, 0, -1, 0, 0, -1, 100);
      n_checks++; if (cfg_error !== 1'b0 || acc_q.size() != 4)
         $display("FAIL legal_after_error got err=%0b jobs=%0d want err=0 jobs=4", cfg_error, acc_q.size()); else n_pass++;
   endtask

   task automatic test_rst_midframe();
      int budget;
      start_frame(4, 3, 2, 0, 0);
      job_ready = 1'b1;
      budget = 0;
      while (!(job_valid && job_x == 3 && job_y == 1) && budget < 40) begin
         step();
         budget++;
      end
      n_checks++; if (budget >= 40) $display("FAIL rst_reach got timeout want pixel (3,1)"); else n_pass++;
      rst = 1'b1;
      #1;
      n_checks++; if (cv_width !== 32'd640 || cv_zoom !== 32'd1 || pix_x !== 0 || pix_y !== 0)
         $display("FAIL rst_values got w=%0d z=%0d pix=(%0d,%0d) want w=640 z=1 pix=(0,0)", cv_width, cv_zoom, pix_x, pix_y);
      else n_pass++;
      n_checks++; if ({job_valid, busy, frame_done} !== 3'b000)
         $display("FAIL rst_flags got %b want 000", {job_valid, busy, frame_done}); else n_pass++;
      job_ready = 1'b0;
      step();
      rst = 1'b0;
      step();
      drive_frame(4, 3, 1, 0, 0, -1, 0, 0, -1, 200);
      n_checks++; if (acc_q.size() != 12 || acc_q[0].x !== 0 || acc_q[0].y !== 0)
         $display("FAIL rst_restart got jobs=%0d first=(%0d,%0d) want jobs=12 first=(0,0)", acc_q.size(),
                  (acc_q.size() > 0) ? acc_q[0].x : -1, (acc_q.size() > 0) ? acc_q[0].y : -1);
      else n_pass++;
   endtask

   task automatic test_random_frames();
      int     w, h, z;
      longint rc, ic;
      for (int k = 0; k < 6; k++) begin
         w  = int'($urandom_range(1, 6));
         h  = int'($urandom_range(1, 4));
         z  = int'($urandom_range(1, 3));
         rc = (longint'($urandom_range(0, 2000)) - 1000) <<< 40;
         ic = (longint'($urandom_range(0, 2000)) - 1000) <<< 40;
         drive_frame(w, h, z, rc, ic, -1, 0, 1, -1, 2000);
         build_expected(w, h, z, rc, ic);
         n_checks++; if (timed_out || acc_q.size() != exp_q.size() || done_after !== 1'b0)
            $display("FAIL rand%0d_frame got timeout=%0b jobs=%0d done_after=%0b want 0/%0d/0",
                     k, timed_out, acc_q.size(), done_after, exp_q.size());
         else n_pass++;
         for (int i = 0; i < acc_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (acc_q[i].x !== exp_q[i].x || acc_q[i].y !== exp_q[i].y || acc_q[i].re !== exp_q[i].re ||
                acc_q[i].im !== exp_q[i].im || acc_q[i].last !== exp_q[i].last)
               $display("FAIL rand%0d_job%0d got (%0d,%0d) re=%0d im=%0d last=%0b want (%0d,%0d) re=%0d im=%0d last=%0b",
                        k, i, acc_q[i].x, acc_q[i].y, acc_q[i].re, acc_q[i].im, acc_q[i].last,
                        exp_q[i].x, exp_q[i].y, exp_q[i].re, exp_q[i].im, exp_q[i].last);
            else n_pass++;
         end
      end
   endtask

   initial begin
      rst = 1'b1;  start = 1'b0;  abort = 1'b0;  job_ready = 1'b0;
      cfg_width = '0;  cfg_height = '0;  cfg_zoom = '0;
      cfg_real_center = '0;  cfg_imag_center = '0;
      test_reset();
      test_basic_frame();
      test_stall();
      test_cfg_change();
      test_abort();
      test_illegal_cfg();
      test_rst_midframe();
      test_random_frames();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
